chk_insert_scheduler: RTL and testbench
=======================================

Name: chk_insert_scheduler

Overview:
- Sequences one 512-bit data stream and one checksum stream onto a single AXI-stream output.
- Forwards BLOCK_BEATS data beats, then exactly one checksum beat, repeating. A frame's tlast also forces the checksum beat early.
- Sits between the payload path and the network TX stream, downstream of the checksum engine.
- Fully honours output backpressure through a registered output stage.

Parameters:
DATA_W, 512, data/checksum beat width
KEEP_W, 64, byte-enable width (DATA_W/8)
ID_W, 6, stream id width
BLOCK_BEATS, 4, data beats per checksum beat (1..15)
CNT_W, 4, beat counter width; must satisfy 2^CNT_W > BLOCK_BEATS

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-low reset
s_data_tdata  in  DATA_W  payload beat
s_data_tkeep  in  KEEP_W  payload byte enables
s_data_tid  in  ID_W  payload stream id
s_data_tlast  in  1  last payload beat of frame
s_data_tvalid  in  1  payload valid
s_data_tready  out  1  payload accepted when high with tvalid
s_chk_tdata  in  DATA_W  checksum beat
s_chk_tkeep  in  KEEP_W  checksum byte enables
s_chk_tid  in  ID_W  checksum stream id
s_chk_tvalid  in  1  checksum valid
s_chk_tready  out  1  checksum accepted when high with tvalid
m_tdata  out  DATA_W  output beat
m_tkeep  out  KEEP_W  output byte enables
m_tid  out  ID_W  output id
m_tlast  out  1  output last
m_tvalid  out  1  output valid
m_tready  in  1  downstream ready
id_err  out  1  one-cycle pulse on checksum/block id mismatch
frames_out  out  32  count of m_tlast beats transferred
chk_beats  out  32  count of checksum beats accepted

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to DATA; beat_cnt=0; frame_last_q=0; blk_id_q=0.
  - All m_* outputs go to 0, including m_tvalid=0. id_err=0; frames_out=0; chk_beats=0.
  - Reset asserted mid-frame discards the output register contents and any partial block without completing it.
- Output slot:
  - slot_free = !m_tvalid || m_tready.
  - The slot register loads only on an accepted input beat. Otherwise it clears m_tvalid when m_tready is high, and holds all m_* stable while m_tvalid && !m_tready.
- Ready outputs are combinational and never depend on their own tvalid:
  - s_data_tready = (state==DATA) && slot_free.
  - s_chk_tready = (state==CHK) && slot_free.
  - At most one of the two is high in any cycle.
- Latency: an accepted beat appears on m_* the next cycle. Full rate is one beat per cycle when m_tready stays high.
- State DATA, on an accepted data beat:
  - m_tdata/tkeep/tid come from s_data_*. m_tlast=0 always; data beats never carry last.
  - blk_id_q is captured from s_data_tid on the first beat of a block (beat_cnt==0).
  - If s_data_tlast==1 or beat_cnt==BLOCK_BEATS-1: go to CHK, beat_cnt=0, frame_last_q=s_data_tlast.
  - Otherwise beat_cnt increments.
- State CHK, on an accepted checksum beat:
  - m_tdata/tkeep/tid come from s_chk_*; m_tlast=frame_last_q.
  - chk_beats increments.
  - If s_chk_tid != blk_id_q, id_err pulses high for that cycle only and the beat is still forwarded.
  - Go to DATA, clear frame_last_q.
- No acceptance means the state holds. A checksum beat presented during DATA waits, and a data beat presented during CHK waits; nothing is dropped.
- frames_out increments on each m_tvalid && m_tready && m_tlast. Both counters wrap modulo 2^32.
- Boundary cases:
  - tlast on the first beat of a block: a single data beat, then the checksum.
  - BLOCK_BEATS==1: data and checksum beats alternate.
  - tlast on beat BLOCK_BEATS-1: a single checksum beat with m_tlast=1, not two.

Test Plan:
- BLOCK_BEATS=4, 8-beat frame (tlast on beat 7), m_tready=1, chk always valid -> output order D0-D3,C0,D4-D7,C1. Only C1 has m_tlast=1; frames_out=1; chk_beats=2; 10 beats in 10 cycles.
- 2-beat frame (tlast on beat 1) -> D0,D1,C(last=1). beat_cnt back to 0; next frame starts a new block.
- m_tready toggling 1,0,0,1 during a block -> m_* held stable while stalled; s_data_tready=0 during stall; no beat duplicated or lost.
- s_chk_tvalid low for 5 cycles after block end -> s_data_tready=0 throughout; data held; checksum forwarded the cycle after it arrives.
- Block data id=6'h05, checksum tid=6'h06 -> id_err high exactly one cycle; beat forwarded with m_tid=6'h06.
- Reset asserted mid-block with m_tvalid=1 -> next cycle m_tvalid=0, counters 0, state DATA. A fresh frame afterwards produces D0 first.

Source files
------------

// File: rtl/chk_insert_scheduler.sv
// Interleaves a payload stream and a checksum stream onto one AXI-stream output:
// BLOCK_BEATS data beats (or fewer when a frame ends), then one checksum beat.
module chk_insert_scheduler #(
    parameter int DATA_W      = 512,
    parameter int KEEP_W      = 64,
    parameter int ID_W        = 6,
    parameter int BLOCK_BEATS = 4,
    parameter int CNT_W       = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] s_data_tdata,
    input  logic [KEEP_W-1:0] s_data_tkeep,
    input  logic [ID_W-1:0]   s_data_tid,
    input  logic              s_data_tlast,
    input  logic              s_data_tvalid,
    output logic              s_data_tready,
    input  logic [DATA_W-1:0] s_chk_tdata,
    input  logic [KEEP_W-1:0] s_chk_tkeep,
    input  logic [ID_W-1:0]   s_chk_tid,
    input  logic              s_chk_tvalid,
    output logic              s_chk_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic [ID_W-1:0]   m_tid,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              id_err,
    output logic [31:0]       frames_out,
    output logic [31:0]       chk_beats
);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_CHK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_BEATS - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                frame_last_q, frame_last_d;
    logic [ID_W-1:0]     blk_id_q, blk_id_d;
    logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
    logic [KEEP_W-1:0]   m_tkeep_q, m_tkeep_d;
    logic [ID_W-1:0]     m_tid_q, m_tid_d;
    logic                m_tlast_q, m_tlast_d;
    logic                m_tvalid_q, m_tvalid_d;
    logic                id_err_q, id_err_d;
    logic [31:0]         frames_q, frames_d;
    logic [31:0]         chk_q, chk_d;
    logic                slot_free_s;

    assign slot_free_s   = !m_tvalid_q || m_tready;
    assign s_data_tready = (state_q == ST_DATA) && slot_free_s;
    assign s_chk_tready  = (state_q == ST_CHK) && slot_free_s;

    // Next-state, output-slot and counter logic.
    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        frame_last_d = frame_last_q;
        blk_id_d     = blk_id_q;
        m_tdata_d    = m_tdata_q;
        m_tkeep_d    = m_tkeep_q;
        m_tid_d      = m_tid_q;
        m_tlast_d    = m_tlast_q;
        m_tvalid_d   = m_tvalid_q;
        id_err_d     = 1'b0;
        chk_d        = chk_q;

        if (m_tready) begin
            m_tvalid_d = 1'b0;
        end else begin
            m_tvalid_d = m_tvalid_q;
        end

        if (m_tvalid_q && m_tready && m_tlast_q) begin
            frames_d = frames_q + 32'd1;
        end else begin
            frames_d = frames_q;
        end

        case (state_q)
            ST_DATA: begin
                if (s_data_tvalid && s_data_tready) begin
                    m_tdata_d  = s_data_tdata;
                    m_tkeep_d  = s_data_tkeep;
                    m_tid_d    = s_data_tid;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    if (beat_cnt_q == {CNT_W{1'b0}}) begin
                        blk_id_d = s_data_tid;
                    end else begin
                        blk_id_d = blk_id_q;
                    end
                    // A frame end closes the block early so its checksum carries tlast.
                    if (s_data_tlast || (beat_cnt_q == LAST_BEAT)) begin
                        state_d      = ST_CHK;
                        beat_cnt_d   = {CNT_W{1'b0}};
                        frame_last_d = s_data_tlast;
                    end else begin
                        beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_CHK: begin
                if (s_chk_tvalid && s_chk_tready) begin
                    m_tdata_d    = s_chk_tdata;
                    m_tkeep_d    = s_chk_tkeep;
                    m_tid_d      = s_chk_tid;
                    m_tlast_d    = frame_last_q;
                    m_tvalid_d   = 1'b1;
                    chk_d        = chk_q + 32'd1;
                    id_err_d     = (s_chk_tid != blk_id_q);
                    state_d      = ST_DATA;
                    frame_last_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d    = ST_DATA;
                beat_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_DATA;
            beat_cnt_q   <= {CNT_W{1'b0}};
            frame_last_q <= 1'b0;
            blk_id_q     <= {ID_W{1'b0}};
            m_tdata_q    <= {DATA_W{1'b0}};
            m_tkeep_q    <= {KEEP_W{1'b0}};
            m_tid_q      <= {ID_W{1'b0}};
            m_tlast_q    <= 1'b0;
            m_tvalid_q   <= 1'b0;
            id_err_q     <= 1'b0;
            frames_q     <= 32'd0;
            chk_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            frame_last_q <= frame_last_d;
            blk_id_q     <= blk_id_d;
            m_tdata_q    <= m_tdata_d;
            m_tkeep_q    <= m_tkeep_d;
            m_tid_q      <= m_tid_d;
            m_tlast_q    <= m_tlast_d;
            m_tvalid_q   <= m_tvalid_d;
            id_err_q     <= id_err_d;
            frames_q     <= frames_d;
            chk_q        <= chk_d;
        end
    end

    assign m_tdata    = m_tdata_q;
    assign m_tkeep    = m_tkeep_q;
    assign m_tid      = m_tid_q;
    assign m_tlast    = m_tlast_q;
    assign m_tvalid   = m_tvalid_q;
    assign id_err     = id_err_q;
    assign frames_out = frames_q;
    assign chk_beats  = chk_q;

endmodule

// File: tb/tb_chk_insert_scheduler.sv
// Directed bench for chk_insert_scheduler: queue-driven sources, an output
// monitor, and hand-written expected beat sequences.
module tb_chk_insert_scheduler;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int ID_W   = 6;

    typedef struct {
        logic [15:0] tag;
        logic [5:0]  id;
        logic        last;
        logic [7:0]  keep;
    } beat_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] s_data_tdata = '0;
    logic [KEEP_W-1:0] s_data_tkeep = '0;
    logic [ID_W-1:0]   s_data_tid = '0;
    logic              s_data_tlast = 1'b0;
    logic              s_data_tvalid = 1'b0;
    logic              s_data_tready;
    logic [DATA_W-1:0] s_chk_tdata = '0;
    logic [KEEP_W-1:0] s_chk_tkeep = '0;
    logic [ID_W-1:0]   s_chk_tid = '0;
    logic              s_chk_tvalid = 1'b0;
    logic              s_chk_tready;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic [ID_W-1:0]   m_tid;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              id_err;
    logic [31:0]       frames_out;
    logic [31:0]       chk_beats;

    chk_insert_scheduler dut (
        .clock(clock), .reset(reset),
        .s_data_tdata(s_data_tdata), .s_data_tkeep(s_data_tkeep), .s_data_tid(s_data_tid),
        .s_data_tlast(s_data_tlast), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
        .s_chk_tdata(s_chk_tdata), .s_chk_tkeep(s_chk_tkeep), .s_chk_tid(s_chk_tid),
        .s_chk_tvalid(s_chk_tvalid), .s_chk_tready(s_chk_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tid(m_tid), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .id_err(id_err), .frames_out(frames_out), .chk_beats(chk_beats)
    );

    always #5 clock = ~clock;

    int    checks_cnt = 0;
    int    errors_cnt = 0;
    int    cyc = 0;
    int    err_pulses = 0;
    logic [5:0] err_tid = '0;
    beat_t dq[$];
    beat_t cq[$];
    beat_t oq[$];
    beat_t eq[$];
    int    ocyc[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] pack(input beat_t b);
        pack = {481'd0, b.keep, b.id, b.last, b.tag};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: records every beat the downstream accepts, plus id_err pulses.
    initial begin
        forever begin
            @(negedge clock);
            if (reset && m_tvalid && m_tready) begin
                oq.push_back('{tag: m_tdata[15:0], id: m_tid, last: m_tlast, keep: m_tkeep[7:0]});
                ocyc.push_back(cyc);
            end
            if (id_err) begin
                err_pulses++;
                err_tid = m_tid;
            end
        end
    end

    // Payload source.
    initial begin
        logic  acc;
        beat_t tmp;
        forever begin
            @(negedge clock);
            acc = s_data_tvalid && s_data_tready;
            @(posedge clock);
            #1;
            if (acc && dq.size() > 0) tmp = dq.pop_front();
            if (dq.size() > 0) begin
                s_data_tvalid = 1'b1;
                s_data_tdata  = {32{dq[0].tag}};
                s_data_tkeep  = {KEEP_W{1'b1}};
                s_data_tid    = dq[0].id;
                s_data_tlast  = dq[0].last;
            end else begin
                s_data_tvalid = 1'b0;
            end
        end
    end

    // Checksum source.
    initial begin
        logic  acc;
        beat_t tmp;
        forever begin
            @(negedge clock);
            acc = s_chk_tvalid && s_chk_tready;
            @(posedge clock);
            #1;
            if (acc && cq.size() > 0) tmp = cq.pop_front();
            if (cq.size() > 0) begin
                s_chk_tvalid = 1'b1;
                s_chk_tdata  = {32{cq[0].tag}};
                s_chk_tkeep  = 64'h0000_0000_0000_000F;
                s_chk_tid    = cq[0].id;
            end else begin
                s_chk_tvalid = 1'b0;
            end
        end
    end

    task automatic push_frame(input logic [15:0] base, input logic [5:0] id, input int n);
        for (int i = 0; i < n; i++)
            dq.push_back('{tag: base + 16'(i), id: id, last: (i == n - 1), keep: 8'hFF});
    endtask

    task automatic push_chk(input logic [15:0] tag, input logic [5:0] id);
        cq.push_back('{tag: tag, id: id, last: 1'b0, keep: 8'h0F});
    endtask

    task automatic exp_d(input logic [15:0] tag, input logic [5:0] id);
        eq.push_back('{tag: tag, id: id, last: 1'b0, keep: 8'hFF});
    endtask

    task automatic exp_c(input logic [15:0] tag, input logic [5:0] id, input logic last);
        eq.push_back('{tag: tag, id: id, last: last, keep: 8'h0F});
    endtask

    task automatic clear_seq();
        oq.delete();
        ocyc.delete();
        eq.delete();
    endtask

    // Returns at posedge+2 once n output beats have been seen, or counts a timeout.
    task automatic wait_out(input string tag, input int n);
        int k;
        k = 0;
        while (oq.size() < n && k < 200) begin
            @(posedge clock);
            #2;
            k++;
        end
        if (oq.size() < n) check({tag, "_timeout"}, oq.size(), n);
    endtask

    task automatic cmp_seq(input string name);
        check({name, "_len"}, oq.size(), eq.size());
        for (int i = 0; i < eq.size(); i++)
            if (i < oq.size()) check($sformatf("%s_%0d", name, i), pack(oq[i]), pack(eq[i]));
    endtask

    task automatic check_counts(input string name, input int fr, input int cb);
        @(negedge clock);
        check({name, "_frames"}, frames_out, fr);
        check({name, "_chk"}, chk_beats, cb);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_frames", frames_out, 0);
        check("rst_chk", chk_beats, 0);
        check("rst_iderr", id_err, 0);
        check("rst_dready", s_data_tready, 1);
        check("rst_cready", s_chk_tready, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;

        // 8-beat frame, two blocks, full rate.
        clear_seq();
        push_chk(16'hC000, 6'd1);
        push_chk(16'hC001, 6'd1);
        push_frame(16'hD000, 6'd1, 8);
        for (int i = 0; i < 4; i++) exp_d(16'hD000 + 16'(i), 6'd1);
        exp_c(16'hC000, 6'd1, 1'b0);
        for (int i = 4; i < 8; i++) exp_d(16'hD000 + 16'(i), 6'd1);
        exp_c(16'hC001, 6'd1, 1'b1);
        wait_out("t1", 10);
        cmp_seq("t1");
        if (ocyc.size() == 10) check("t1_rate", ocyc[9] - ocyc[0], 9);
        check_counts("t1", 1, 2);

        // 2-beat frame closes the block early.
        @(posedge clock);
        #2;
        clear_seq();
        push_chk(16'hC010, 6'd2);
        push_frame(16'hD010, 6'd2, 2);
        exp_d(16'hD010, 6'd2);
        exp_d(16'hD011, 6'd2);
        exp_c(16'hC010, 6'd2, 1'b1);
        wait_out("t2", 3);
        cmp_seq("t2");
        check_counts("t2", 2, 3);

        // 4-beat frame (tlast on last block beat) with a two-cycle output stall.
        @(posedge clock);
        #2;
        clear_seq();
        push_chk(16'hC020, 6'd3);
        push_frame(16'hD020, 6'd3, 4);
        for (int i = 0; i < 4; i++) exp_d(16'hD020 + 16'(i), 6'd3);
        exp_c(16'hC020, 6'd3, 1'b1);
        wait_out("t3a", 1);
        m_tready = 1'b0;
        @(negedge clock);
        check("stall1_valid", m_tvalid, 1);
        check("stall1_data", m_tdata[15:0], 16'hD021);
        check("stall1_dready", s_data_tready, 0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("stall2_valid", m_tvalid, 1);
        check("stall2_data", m_tdata[15:0], 16'hD021);
        check("stall2_dready", s_data_tready, 0);
        @(posedge clock);
        #1;
        m_tready = 1'b1;
        wait_out("t3", 5);
        cmp_seq("t3");
        check_counts("t3", 3, 4);

        // Single-beat frames; checksum arrives late.
        @(posedge clock);
        #2;
        clear_seq();
        push_frame(16'hD030, 6'd4, 1);
        push_frame(16'hD040, 6'd5, 1);
        exp_d(16'hD030, 6'd4);
        exp_c(16'hC030, 6'd4, 1'b1);
        exp_d(16'hD040, 6'd5);
        exp_c(16'hC040, 6'd5, 1'b1);
        wait_out("t4a", 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("t4_dready_%0d", i), s_data_tready, 0);
        end
        @(posedge clock);
        #2;
        push_chk(16'hC030, 6'd4);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("t4_chk_pending", m_tvalid, 0);
        @(negedge clock);
        check("t4_chk_valid", m_tvalid, 1);
        check("t4_chk_data", m_tdata[15:0], 16'hC030);
        @(posedge clock);
        #2;
        push_chk(16'hC040, 6'd5);
        wait_out("t4", 4);
        cmp_seq("t4");
        check_counts("t4", 5, 6);
        check("t4_no_iderr", err_pulses, 0);

        // Checksum id differs from block id.
        @(posedge clock);
        #2;
        clear_seq();
        push_chk(16'hC050, 6'h06);
        push_frame(16'hD050, 6'h05, 2);
        exp_d(16'hD050, 6'h05);
        exp_d(16'hD051, 6'h05);
        exp_c(16'hC050, 6'h06, 1'b1);
        wait_out("t5", 3);
        cmp_seq("t5");
        check_counts("t5", 6, 7);
        check("t5_iderr_pulses", err_pulses, 1);
        check("t5_iderr_tid", err_tid, 6'h06);

        // Reset mid-block, then a fresh frame.
        @(posedge clock);
        #2;
        clear_seq();
        push_chk(16'hC060, 6'd7);
        push_frame(16'hD060, 6'd7, 8);
        wait_out("t6a", 2);
        check("t6_pre_valid", m_tvalid, 1);
        reset = 1'b0;
        dq.delete();
        cq.delete();
        @(posedge clock);
        #1;
        @(negedge clock);
        check("t6_rst_valid", m_tvalid, 0);
        check("t6_rst_frames", frames_out, 0);
        check("t6_rst_chk", chk_beats, 0);
        check("t6_rst_dready", s_data_tready, 1);
        check("t6_rst_cready", s_chk_tready, 0);
        @(posedge clock);
        #2;
        reset = 1'b1;
        clear_seq();
        push_chk(16'hC070, 6'd8);
        push_frame(16'hD070, 6'd8, 2);
        exp_d(16'hD070, 6'd8);
        exp_d(16'hD071, 6'd8);
        exp_c(16'hC070, 6'd8, 1'b1);
        wait_out("t6", 3);
        cmp_seq("t6");
        check_counts("t6", 1, 1);

        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
